// File: rtl/ssp_rx_shifter.sv
// SSP serial receive front end: synchronises the serial clock, frame sync and data,
// deserialises TI-format 8-bit MSB-first frames and hands each byte to the receive FIFO.
module ssp_rx_shifter (
  input  logic       i_pclk,
  input  logic       i_clear_b,
  input  logic       i_sspclkin,
  input  logic       i_sspfssin,
  input  logic       i_ssprxd,
  input  logic       i_ssprxintr,
  output logic [7:0] o_rxdata,
  output logic       o_rcv,
  output logic       o_rxoverrun,
  output logic       o_rxbusy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic       r_clk_meta;
  logic       r_clk_sync;
  logic       r_clk_prev;
  logic       r_fss_meta;
  logic       r_fss_sync;
  logic       r_rxd_meta;
  logic       r_rxd_sync;
  logic [0:0] r_state;
  logic [2:0] r_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_rxdata;
  logic       r_pending;
  logic       r_overrun;

  logic       w_fe;
  logic       w_done;
  logic       w_rcv;
  logic [7:0] w_byte;

  assign w_fe   = r_clk_prev & ~r_clk_sync;
  assign w_byte = {r_shift[6:0], r_rxd_sync};
  assign w_done = w_fe & (r_state == ST_SHIFT) & (r_cnt == 3'd0);
  assign w_rcv  = r_pending & ~i_ssprxintr;

  // Two-flop synchronisers; the extra clock flop gives the falling-edge detect.
  always_ff @(posedge i_pclk or negedge i_clear_b) begin
    if (!i_clear_b) begin
      r_clk_meta <= 1'b0;
      r_clk_sync <= 1'b0;
      r_clk_prev <= 1'b0;
      r_fss_meta <= 1'b0;
      r_fss_sync <= 1'b0;
      r_rxd_meta <= 1'b0;
      r_rxd_sync <= 1'b0;
    end else begin
      r_clk_meta <= i_sspclkin;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_fss_meta <= i_sspfssin;
      r_fss_sync <= r_fss_meta;
      r_rxd_meta <= i_ssprxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  // Frame state machine and shift register, advanced only on serial falling edges.
  always_ff @(posedge i_pclk or negedge i_clear_b) begin
    if (!i_clear_b) begin
      r_state <= ST_IDLE;
      r_cnt   <= 3'd0;
      r_shift <= 8'h00;
    end else if (w_fe) begin
      case (r_state)
        ST_IDLE: begin
          if (r_fss_sync) begin
            r_state <= ST_SHIFT;
            r_cnt   <= 3'd7;
          end
        end
        ST_SHIFT: begin
          r_shift <= w_byte;
          if (r_cnt == 3'd0) begin
            // A frame sync on the last bit chains straight into the next frame.
            r_cnt   <= 3'd7;
            r_state <= r_fss_sync ? ST_SHIFT : ST_IDLE;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 3'd0;
        end
      endcase
    end
  end

  // FIFO handoff: a completing byte takes priority over the strobe clearing pending.
  always_ff @(posedge i_pclk or negedge i_clear_b) begin
    if (!i_clear_b) begin
      r_rxdata  <= 8'h00;
      r_pending <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      if (!r_pending || w_rcv) begin
        r_rxdata  <= w_byte;
        r_pending <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (w_rcv) begin
      r_pending <= 1'b0;
    end
  end

  assign o_rxdata    = r_rxdata;
  assign o_rcv       = w_rcv;
  assign o_rxoverrun = r_overrun;
  assign o_rxbusy    = (r_state == ST_SHIFT);

endmodule

// File: doc/ssp_rx_shifter.md
# ssp_rx_shifter

Serial receive front end of the SSP, directly upstream of the receive FIFO. It synchronises the external serial clock, frame-sync and data lines into the `pclk` domain and deserialises TI-synchronous-format 8-bit frames, MSB first. Each completed byte is presented on `rxdata` and strobed into the FIFO with `rcv`. A byte is held while the FIFO reports full, and a sticky overrun flag is raised if a further byte is lost.

## Interface
- No parameters; frame width is fixed at 8 bits.
- `pclk`  in  1  system clock; all state updates on its rising edge.
- `clear_b`  in  1  asynchronous, active-low reset.
- `sspclkin`  in  1  external serial clock, asynchronous to `pclk`.
- `sspfssin`  in  1  external frame sync, one serial-clock period wide, asynchronous.
- `ssprxd`  in  1  external serial data, asynchronous.
- `ssprxintr`  in  1  FIFO full indication from the receive FIFO; FIFO accepts only while low.
- `rxdata`  out  8  last completed byte; stable while `rcv` is pending.
- `rcv`  out  1  write strobe to the FIFO.
- `rxoverrun`  out  1  sticky; a completed byte was discarded.
- `rxbusy`  out  1  high while a frame is being shifted in.

## Operation
- Synchronisation:
  - `sspclkin`, `sspfssin` and `ssprxd` each pass through a 2-flop synchroniser.
  - A third flop on the clock path provides edge detection.
  - Falling-edge event `fe` = previous synced clock 1 AND current synced clock 0.
  - All sampling happens only on `fe` cycles, using the synced `fss` and `rxd` values of that same cycle.
- State machine, states IDLE and SHIFT, plus a 3-bit bit counter `cnt`:
  - IDLE: on `fe` with `fss`=1, go to SHIFT with `cnt`=7. All other input is ignored.
  - SHIFT: on each `fe`, shift `rxd` into bit 0 of the shift register (MSB arrives first) and decrement `cnt`.
  - SHIFT, `fe` at `cnt`=0 (eighth bit): the frame completes. The full byte goes to the completion logic below.
    - If `fss`=1 on that same `fe`, reload `cnt`=7 and stay in SHIFT (back-to-back frame).
    - Otherwise go to IDLE.
  - `fss`=1 on any other SHIFT `fe` is ignored and does not restart the frame.
- Completion and FIFO handshake, using an internal `pending` bit:
  - If `pending`=0: load `rxdata` with the completed byte and set `pending`.
  - If `pending`=1: discard the byte, leave `rxdata` unchanged and set `rxoverrun`.
  - `rcv` = `pending` AND NOT `ssprxintr`, combinational.
  - `pending` clears on the first `pclk` edge at which `rcv`=1. Each accepted byte therefore gives exactly one `rcv` cycle.
  - If completion and clear fall on the same edge, completion wins: `rxdata` loads, `pending` stays 1, and no overrun is flagged.
- `rxbusy` = state is SHIFT.
- `rxoverrun` clears only through `clear_b`.

## Timing
- Reset (`clear_b` low, asynchronous):
  - All outputs go to 0: `rxdata`=8'h00, `rcv`=0, `rxoverrun`=0, `rxbusy`=0.
  - State goes to IDLE, `pending`=0, `cnt`=0, shift register 0, synchroniser flops 0.
  - A frame in progress is abandoned; no partial byte is ever delivered.
- Input constraints:
  - Each `sspclkin` high phase and low phase lasts at least 2 `pclk` cycles (period ≥4 `pclk`).
  - `sspfssin` and `ssprxd` are stable around the serial-clock falling edge.
- Latency:
  - `fe` is asserted 3 `pclk` edges after the pin-level falling edge of `sspclkin`.
  - `rxdata` updates on the `fe` edge of the eighth bit.
  - `rcv` goes high in the following cycle if `ssprxintr`=0.
- While `ssprxintr`=1, `rcv` stays 0 and `rxdata` is held. `rcv` rises in the first cycle after `ssprxintr` falls.
- Back-to-back frames require no idle serial clock between them.

## Test plan
- Single frame:
  - Stimulus: `fss` pulse, then bits of 8'hA5, `ssprxintr`=0.
  - Required: `rxbusy` high for 8 serial periods; `rxdata`=8'hA5; `rcv` high exactly 1 `pclk`; `rxoverrun`=0.
- Back-to-back frames:
  - Stimulus: 8'h3C then 8'hC3 with `fss` during the LSB of the first frame.
  - Required: two single-cycle `rcv` pulses carrying 3C, then C3; `rxbusy` never drops between the frames.
- FIFO full, then drained:
  - Stimulus: `ssprxintr`=1, send 8'h5A, then release `ssprxintr` 20 cycles later.
  - Required: `rcv`=0 while `ssprxintr`=1; one `rcv` cycle with `rxdata`=8'h5A after release.
- Overrun:
  - Stimulus: `ssprxintr` held 1, send 8'h11 then 8'h22.
  - Required: `rxdata` stays 8'h11; `rxoverrun`=1. On release, one `rcv` delivers 11 only, and `rxoverrun` stays 1.
- Reset mid-frame and spurious `fss`:
  - Stimulus: assert `clear_b` low after 4 bits. Then send a frame with an extra `fss` pulse at bit 3, data 8'hF0.
  - Required: all outputs 0 immediately on reset; no `rcv` for the aborted frame; the next frame delivers 8'hF0 unaffected by the extra `fss`.
